conv_weight_loader: RTL

//  Byte-stream loader that fills the conv weights RAM (L1+L2, 4752 B) and the conv biases RAM
//  (48 x 32b) from the host link. Sits between the UART receiver and both conv RAMs' write ports.

---
 rtl/conv_weight_loader_pkg.sv | 26 ++
 rtl/conv_weight_loader.sv | 96 +++++++++
 2 files changed

// File: rtl/conv_weight_loader_pkg.sv
// Shared constants and state encoding for the conv weight/bias loader.
package conv_weight_loader_pkg;

    localparam int N_WEIGHTS = 4752;
    localparam int N_BIASES  = 48;

    localparam int L1_W_BASE = 0;
    localparam int L2_W_BASE = 144;
    localparam int L1_N_BIAS = 16;
    localparam int L2_N_BIAS = 32;

    localparam logic [7:0] SYNC_B0 = 8'hAA;
    localparam logic [7:0] SYNC_B1 = 8'h55;

    localparam logic [12:0] W_LAST = 13'(N_WEIGHTS - 1);
    localparam logic [5:0]  B_LAST = 6'(N_BIASES - 1);

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_SYNC,
        ST_LOAD_W,
        ST_LOAD_B,
        ST_DONE
    } state_e;

endpackage

// File: rtl/conv_weight_loader.sv
// Streams host bytes into the conv weights RAM and packs bias bytes into
// 32-bit little-endian words for the conv biases RAM after a 2-byte header.
module conv_weight_loader
    import conv_weight_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [12:0] w_wr_addr,
    output logic [7:0]  w_wr_data,
    output logic        w_wr_en,
    output logic [5:0]  b_wr_addr,
    output logic [31:0] b_wr_data,
    output logic        b_wr_en,
    output logic        busy,
    output logic        load_done
);

    state_e      state_q;
    logic [12:0] w_cnt_q;
    logic [5:0]  b_cnt_q;
    logic [1:0]  lane_q;
    logic [23:0] sh_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_HUNT;
            w_cnt_q   <= '0;
            b_cnt_q   <= '0;
            lane_q    <= '0;
            sh_q      <= '0;
            w_wr_addr <= '0;
            w_wr_data <= '0;
            w_wr_en   <= 1'b0;
            b_wr_addr <= '0;
            b_wr_data <= '0;
            b_wr_en   <= 1'b0;
            busy      <= 1'b0;
            load_done <= 1'b0;
        end else begin
            w_wr_en <= 1'b0;
            b_wr_en <= 1'b0;
            if (rx_valid) begin
                unique case (state_q)
                    ST_HUNT, ST_DONE: begin
                        if (rx_data == SYNC_B0) state_q <= ST_SYNC;
                    end
                    ST_SYNC: begin
                        if (rx_data == SYNC_B1) begin
                            state_q   <= ST_LOAD_W;
                            busy      <= 1'b1;
                            load_done <= 1'b0;
                            w_cnt_q   <= '0;
                        end else if (rx_data != SYNC_B0) begin
                            state_q <= ST_HUNT;
                        end
                    end
                    ST_LOAD_W: begin
                        w_wr_addr <= w_cnt_q;
                        w_wr_data <= rx_data;
                        w_wr_en   <= 1'b1;
                        if (w_cnt_q == W_LAST) begin
                            state_q <= ST_LOAD_B;
                            b_cnt_q <= '0;
                            lane_q  <= '0;
                        end else begin
                            w_cnt_q <= w_cnt_q + 13'd1;
                        end
                    end
                    ST_LOAD_B: begin
                        // Lanes 0..2 accumulate; lane 3 completes the word.
                        if (lane_q == 2'd3) begin
                            b_wr_addr <= b_cnt_q;
                            b_wr_data <= {rx_data, sh_q};
                            b_wr_en   <= 1'b1;
                            lane_q    <= '0;
                            if (b_cnt_q == B_LAST) begin
                                state_q   <= ST_DONE;
                                busy      <= 1'b0;
                                load_done <= 1'b1;
                            end else begin
                                b_cnt_q <= b_cnt_q + 6'd1;
                            end
                        end else begin
                            sh_q   <= {rx_data, sh_q[23:8]};
                            lane_q <= lane_q + 2'd1;
                        end
                    end
                    default: state_q <= ST_HUNT;
                endcase
            end
        end
    end

endmodule
